// File: rtl/uart_rx_param.sv
// rtl/uart_rx_param.sv - parametrised UART receiver with glitch rejection, majority voting and error/break reporting
module uart_rx_param #(
  parameter int CLK_DIV   = 5208,
  parameter int DATA_BITS = 8,
  parameter int PARITY    = 0,
  parameter int STOP_BITS = 1
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rx_uart,
  output logic [DATA_BITS-1:0] dout,
  output logic                 dout_vld,
  output logic                 parity_err,
  output logic                 frame_err,
  output logic                 break_det,
  output logic                 busy
);

  localparam int            CW        = $clog2(CLK_DIV);
  localparam logic [CW-1:0] SAMPLE_PT = CW'(CLK_DIV / 2 - 1);
  localparam logic [CW-1:0] CNT_MAX   = CW'(CLK_DIV - 1);
  localparam logic [3:0]    LAST_DATA = 4'(DATA_BITS - 1);
  localparam logic [3:0]    LAST_STOP = 4'(STOP_BITS - 1);
  localparam bit            PAR_EN    = (PARITY != 0);
  // XOR of data and parity bit that a correct frame produces: 1 for odd, 0 for even
  localparam logic          PAR_GOOD  = (PARITY == 1);

  typedef enum logic [2:0] {
    S_IDLE,
    S_START,
    S_DATA,
    S_PAR,
    S_STOP,
    S_WAIT
  } state_t;

  state_t               state;
  state_t               state_n;
  logic                 rx_m;
  logic                 rx_s;
  logic                 rx_d;
  logic                 rx_d2;
  logic [CW-1:0]        cnt;
  logic [3:0]           idx;
  logic [DATA_BITS-1:0] shreg;
  logic                 par_smp;
  logic                 stop_err;
  logic                 all_low;
  logic                 fall;
  logic                 maj;
  logic                 sample;
  logic                 idx_last;
  logic                 stop_bad;
  logic                 par_bad;
  logic                 finish;

  // Two-flop synchroniser plus two history flops for edge detect and voting
  always_ff @(posedge clk) begin
    if (rst) begin
      rx_m  <= 1'b1;
      rx_s  <= 1'b1;
      rx_d  <= 1'b1;
      rx_d2 <= 1'b1;
    end else begin
      rx_m  <= rx_uart;
      rx_s  <= rx_m;
      rx_d  <= rx_s;
      rx_d2 <= rx_d;
    end
  end

  assign fall     = rx_d & ~rx_s;
  assign maj      = (rx_s & rx_d) | (rx_s & rx_d2) | (rx_d & rx_d2);
  assign sample   = (cnt == SAMPLE_PT);
  assign idx_last = (state == S_DATA) ? (idx == LAST_DATA) : (idx == LAST_STOP);
  // Stop error including the stop bit being sampled this cycle
  assign stop_bad = stop_err | ~maj;
  assign par_bad  = PAR_EN ? ((^shreg ^ par_smp) != PAR_GOOD) : 1'b0;
  assign busy     = (state != S_IDLE);

  // State register
  always_ff @(posedge clk) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_n;
    end
  end

  // Next-state logic; finish marks the last stop-bit sample of a frame
  always_comb begin
    state_n = state;
    finish  = 1'b0;
    case (state)
      S_IDLE: begin
        if (fall) begin
          state_n = S_START;
        end
      end
      S_START: begin
        if (sample) begin
          state_n = maj ? S_IDLE : S_DATA;
        end
      end
      S_DATA: begin
        if (sample && idx_last) begin
          state_n = PAR_EN ? S_PAR : S_STOP;
        end
      end
      S_PAR: begin
        if (sample) begin
          state_n = S_STOP;
        end
      end
      S_STOP: begin
        if (sample && idx_last) begin
          finish  = 1'b1;
          state_n = stop_bad ? S_WAIT : S_IDLE;
        end
      end
      S_WAIT: begin
        if (rx_s && (cnt == CNT_MAX)) begin
          state_n = S_IDLE;
        end
      end
      default: state_n = S_IDLE;
    endcase
  end

  // Baud counter: held at 0 in IDLE so it starts from 0 the cycle after the start edge;
  // in WAIT it measures how long the line has been continuously high
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
    end else if (state == S_IDLE) begin
      cnt <= '0;
    end else if (state == S_WAIT) begin
      cnt <= (!rx_s || (cnt == CNT_MAX)) ? '0 : cnt + 1'b1;
    end else if (state_n == S_WAIT) begin
      cnt <= '0;
    end else begin
      cnt <= (cnt == CNT_MAX) ? '0 : cnt + 1'b1;
    end
  end

  // Bit index within the data field and within the stop field
  always_ff @(posedge clk) begin
    if (rst) begin
      idx <= '0;
    end else if (state == S_IDLE) begin
      idx <= '0;
    end else if (sample && ((state == S_DATA) || (state == S_STOP))) begin
      idx <= idx_last ? 4'd0 : idx + 4'd1;
    end
  end

  // Frame capture: shift register, parity sample, stop error and all-low tracking
  always_ff @(posedge clk) begin
    if (rst) begin
      shreg    <= '0;
      par_smp  <= 1'b0;
      stop_err <= 1'b0;
      all_low  <= 1'b0;
    end else if (state == S_IDLE) begin
      stop_err <= 1'b0;
      all_low  <= 1'b1;
    end else if (sample) begin
      case (state)
        S_DATA: begin
          shreg   <= {maj, shreg[DATA_BITS-1:1]};
          all_low <= all_low & ~maj;
        end
        S_PAR: begin
          par_smp <= maj;
          all_low <= all_low & ~maj;
        end
        S_STOP: begin
          stop_err <= stop_bad;
          all_low  <= all_low & ~maj;
        end
        default: ;
      endcase
    end
  end

  // Output register: word and flags are presented together for one cycle
  always_ff @(posedge clk) begin
    if (rst) begin
      dout       <= '0;
      dout_vld   <= 1'b0;
      parity_err <= 1'b0;
      frame_err  <= 1'b0;
      break_det  <= 1'b0;
    end else begin
      dout_vld   <= finish;
      parity_err <= finish & par_bad;
      frame_err  <= finish & stop_bad;
      break_det  <= finish & all_low & ~maj;
      if (finish) begin
        dout <= shreg;
      end
    end
  end

endmodule

// File: tb/tb_uart_rx_param.sv
// tb/tb_uart_rx_param.sv - directed bench for uart_rx_param in 8N1, 8E1 and 7N2 configurations
module tb_uart_rx_param;

  localparam int DIV = 16;

  typedef struct packed {
    logic [31:0] cyc;
    logic [8:0]  d;
    logic        pe;
    logic        fe;
    logic        bd;
  } rec_t;

  logic       clk;
  logic       rst;
  logic       rx_a, rx_p, rx_s2;
  logic [7:0] dout_a, dout_p;
  logic [6:0] dout_s;
  logic       vld_a, pe_a, fe_a, bd_a, busy_a;
  logic       vld_p, pe_p, fe_p, bd_p, busy_p;
  logic       vld_s, pe_s, fe_s, bd_s, busy_s;

  int   cyc;
  int   total;
  int   bad;
  rec_t q_a[$];
  rec_t q_p[$];
  rec_t q_s[$];

  uart_rx_param #(.CLK_DIV(DIV), .DATA_BITS(8), .PARITY(0), .STOP_BITS(1)) dut_a (
    .clk(clk), .rst(rst), .rx_uart(rx_a), .dout(dout_a), .dout_vld(vld_a),
    .parity_err(pe_a), .frame_err(fe_a), .break_det(bd_a), .busy(busy_a)
  );

  uart_rx_param #(.CLK_DIV(DIV), .DATA_BITS(8), .PARITY(2), .STOP_BITS(1)) dut_p (
    .clk(clk), .rst(rst), .rx_uart(rx_p), .dout(dout_p), .dout_vld(vld_p),
    .parity_err(pe_p), .frame_err(fe_p), .break_det(bd_p), .busy(busy_p)
  );

  uart_rx_param #(.CLK_DIV(DIV), .DATA_BITS(7), .PARITY(0), .STOP_BITS(2)) dut_s (
    .clk(clk), .rst(rst), .rx_uart(rx_s2), .dout(dout_s), .dout_vld(vld_s),
    .parity_err(pe_s), .frame_err(fe_s), .break_det(bd_s), .busy(busy_s)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  always @(posedge clk) cyc <= cyc + 1;

  function automatic rec_t mk(input int c, input logic [8:0] d, input logic pe,
                              input logic fe, input logic bd);
    rec_t r;
    r.cyc = c;
    r.d   = d;
    r.pe  = pe;
    r.fe  = fe;
    r.bd  = bd;
    return r;
  endfunction

  always @(negedge clk) begin
    if (vld_a) q_a.push_back(mk(cyc, {1'b0, dout_a}, pe_a, fe_a, bd_a));
    if (vld_p) q_p.push_back(mk(cyc, {1'b0, dout_p}, pe_p, fe_p, bd_p));
    if (vld_s) q_s.push_back(mk(cyc, {2'b0, dout_s}, pe_s, fe_s, bd_s));
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic set_line(input int which, input logic b);
    case (which)
      0:       rx_a  = b;
      1:       rx_p  = b;
      default: rx_s2 = b;
    endcase
  endtask

  // Drives bits[0] first, each for one bit period; returns at edge + 1
  task automatic send_bits(input int which, input logic [15:0] bits, input int n);
    for (int i = 0; i < n; i++) begin
      set_line(which, bits[i]);
      repeat (DIV) @(posedge clk);
      #1;
    end
  endtask

  task automatic chk_frame(input string tag, input int which, input int exp_cyc,
                           input logic [8:0] exp_d, input logic exp_pe,
                           input logic exp_fe, input logic exp_bd);
    rec_t r;
    r = '0;
    case (which)
      0:       if (q_a.size() > 0) r = q_a.pop_front();
      1:       if (q_p.size() > 0) r = q_p.pop_front();
      default: if (q_s.size() > 0) r = q_s.pop_front();
    endcase
    chk({tag, ".cyc"}, r.cyc, exp_cyc);
    chk({tag, ".dout"}, 32'(r.d), 32'(exp_d));
    chk({tag, ".parity_err"}, 32'(r.pe), 32'(exp_pe));
    chk({tag, ".frame_err"}, 32'(r.fe), 32'(exp_fe));
    chk({tag, ".break_det"}, 32'(r.bd), 32'(exp_bd));
  endtask

  initial begin
    int e0;
    int e1;
    cyc   = 0;
    total = 0;
    bad   = 0;
    rst   = 1'b1;
    rx_a  = 1'b1;
    rx_p  = 1'b1;
    rx_s2 = 1'b1;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;

    // Reset state
    chk("rst.dout", 32'(dout_a), 32'h0);
    chk("rst.dout_vld", 32'(vld_a), 32'h0);
    chk("rst.busy", 32'(busy_a), 32'h0);
    chk("rst.frame_err", 32'(fe_a), 32'h0);
    chk("rst.break_det", 32'(bd_a), 32'h0);
    repeat (2) @(posedge clk);
    #1;

    // 8N1 0xA5: pulse at t0 + 9*16 + 8 + 1 with t0 = drive cycle + 2
    e0 = cyc;
    send_bits(0, {6'b0, 1'b1, 8'hA5, 1'b0}, 10);
    repeat (4) @(posedge clk);
    #1;
    chk("a5.count", q_a.size(), 1);
    chk_frame("a5", 0, e0 + 155, 9'h0A5, 1'b0, 1'b0, 1'b0);
    chk("a5.hold", 32'(dout_a), 32'hA5);
    chk("a5.vld_low", 32'(vld_a), 32'h0);
    chk("a5.busy_low", 32'(busy_a), 32'h0);

    // Back-to-back frames with zero idle time
    e0 = cyc;
    send_bits(0, {6'b0, 1'b1, 8'h5A, 1'b0}, 10);
    send_bits(0, {6'b0, 1'b1, 8'hC3, 1'b0}, 10);
    repeat (4) @(posedge clk);
    #1;
    chk("b2b.count", q_a.size(), 2);
    chk_frame("b2b1", 0, e0 + 155, 9'h05A, 1'b0, 1'b0, 1'b0);
    chk_frame("b2b2", 0, e0 + 160 + 155, 9'h0C3, 1'b0, 1'b0, 1'b0);

    // Reset mid-DATA of 0xFF: start plus three data bits, then one reset cycle
    send_bits(0, 16'b1110, 4);
    chk("mid.busy", 32'(busy_a), 32'h1);
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    chk("mid_rst.busy", 32'(busy_a), 32'h0);
    chk("mid_rst.dout", 32'(dout_a), 32'h0);
    chk("mid_rst.vld", 32'(vld_a), 32'h0);
    repeat (200) @(posedge clk);
    #1;
    chk("mid_rst.no_out", q_a.size(), 0);
    e0 = cyc;
    send_bits(0, {6'b0, 1'b1, 8'h3C, 1'b0}, 10);
    repeat (4) @(posedge clk);
    #1;
    chk("3c.count", q_a.size(), 1);
    chk_frame("3c", 0, e0 + 155, 9'h03C, 1'b0, 1'b0, 1'b0);

    // 8E1 0x03: parity bit 1 is wrong, then parity bit 0 is right
    e0 = cyc;
    send_bits(1, {5'b0, 1'b1, 1'b1, 8'h03, 1'b0}, 11);
    send_bits(1, {5'b0, 1'b1, 1'b0, 8'h03, 1'b0}, 11);
    repeat (4) @(posedge clk);
    #1;
    chk("par.count", q_p.size(), 2);
    chk_frame("par_bad", 1, e0 + 171, 9'h003, 1'b1, 1'b0, 1'b0);
    chk_frame("par_ok", 1, e0 + 176 + 171, 9'h003, 1'b0, 1'b0, 1'b0);

    // Glitch: three low cycles; START sample at t0+8 rejects it
    e0 = cyc;
    set_line(0, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    set_line(0, 1'b1);
    chk("glitch.busy_rise", 32'(busy_a), 32'h1);
    repeat (7) @(posedge clk);
    #1;
    chk("glitch.busy_t0p8", 32'(busy_a), 32'h1);
    @(posedge clk);
    #1;
    chk("glitch.busy_t0p9", 32'(busy_a), 32'h0);
    repeat (200) @(posedge clk);
    #1;
    chk("glitch.no_out", q_a.size(), 0);

    // Break: line low for three frame times
    e0 = cyc;
    set_line(0, 1'b0);
    repeat (200) @(posedge clk);
    #1;
    chk("brk.busy_wait", 32'(busy_a), 32'h1);
    repeat (280) @(posedge clk);
    #1;
    chk("brk.count", q_a.size(), 1);
    chk_frame("brk", 0, e0 + 155, 9'h000, 1'b0, 1'b1, 1'b1);
    set_line(0, 1'b1);
    repeat (17) @(posedge clk);
    #1;
    chk("brk.busy_h15", 32'(busy_a), 32'h1);
    @(posedge clk);
    #1;
    chk("brk.busy_h16", 32'(busy_a), 32'h0);
    repeat (100) @(posedge clk);
    #1;
    chk("brk.no_retrig", q_a.size(), 0);

    // 7N2: second stop bit of 0x55 low, idle, then 0x2A
    e0 = cyc;
    send_bits(2, {6'b0, 1'b0, 1'b1, 7'h55, 1'b0}, 10);
    set_line(2, 1'b1);
    repeat (24) @(posedge clk);
    #1;
    e1 = cyc;
    send_bits(2, {6'b0, 1'b1, 1'b1, 7'h2A, 1'b0}, 10);
    repeat (4) @(posedge clk);
    #1;
    chk("stop2.count", q_s.size(), 2);
    chk_frame("stop2_f1", 2, e0 + 155, 9'h055, 1'b0, 1'b1, 1'b0);
    chk_frame("stop2_f2", 2, e1 + 155, 9'h02A, 1'b0, 1'b0, 1'b0);
    chk("stop2.busy", 32'(busy_s), 32'h0);
    chk("stop2.dout", 32'(dout_s), 32'h2A);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
